// File: rtl/alu_mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : alu_mdu_ctrl_if
// Brief  : EX-stage decode/MDU bundle between the pipeline and alu_mdu_ctrl.
// Rev    : 1.0
// ============================================================================
interface alu_mdu_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            i_flush;
  logic            i_alu_dec;
  logic [2:0]      i_funct3;
  logic [6:0]      i_funct7;
  logic            i_opcode5;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [3:0]      o_alu_op;
  logic            o_is_mdu;
  logic            o_stall;
  logic            o_mdu_valid;
  logic [XLEN-1:0] o_mdu_result;

  modport master (
    output i_valid, i_flush, i_alu_dec, i_funct3, i_funct7, i_opcode5, i_rs1, i_rs2,
    input  o_alu_op, o_is_mdu, o_stall, o_mdu_valid, o_mdu_result
  );

  modport slave (
    input  i_valid, i_flush, i_alu_dec, i_funct3, i_funct7, i_opcode5, i_rs1, i_rs2,
    output o_alu_op, o_is_mdu, o_stall, o_mdu_valid, o_mdu_result
  );
endinterface
`default_nettype wire

// File: rtl/alu_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_mdu_ctrl
// Brief  : ALU-op decoder with a sequenced RV32M shift-add multiplier and
//          restoring divider that stalls the pipeline while it iterates.
// Rev    : 1.0
// ============================================================================
module alu_mdu_ctrl #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  alu_mdu_ctrl_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;
  logic            sa_q, sa_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            w_is_mdu;
  logic            w_accept;
  logic            w_is_div;
  logic            w_sa, w_sb;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div0, w_ovf;
  logic [XLEN-1:0] w_special;
  logic            w_last;

  assign w_is_mdu = M_EXT & bus.i_alu_dec & bus.i_opcode5 & (bus.i_funct7 == 7'b0000001);
  assign w_accept = (state_q == S_IDLE) & bus.i_valid & w_is_mdu & ~bus.i_flush;

  always_comb begin
    bus.o_alu_op = 4'b0000;
    if (bus.i_alu_dec) begin
      case (bus.i_funct3)
        3'b000:  bus.o_alu_op = (bus.i_funct7[5] & bus.i_opcode5) ? 4'b0001 : 4'b0000;
        3'b001:  bus.o_alu_op = 4'b0010;
        3'b010:  bus.o_alu_op = 4'b0011;
        3'b011:  bus.o_alu_op = 4'b0100;
        3'b100:  bus.o_alu_op = 4'b0101;
        3'b101:  bus.o_alu_op = bus.i_funct7[5] ? 4'b0111 : 4'b0110;
        3'b110:  bus.o_alu_op = 4'b1000;
        default: bus.o_alu_op = 4'b1001;
      endcase
    end
  end

  // Operand signedness: MUL/MULH/MULHSU sign rs1, MUL/MULH sign rs2, DIV/REM sign both.
  assign w_is_div = bus.i_funct3[2];
  assign w_sa = (w_is_div ? ~bus.i_funct3[0] : ~(bus.i_funct3[1] & bus.i_funct3[0]))
                & bus.i_rs1[XLEN-1];
  assign w_sb = (w_is_div ? ~bus.i_funct3[0] : ~bus.i_funct3[1]) & bus.i_rs2[XLEN-1];
  assign w_mag_a = w_sa ? -bus.i_rs1 : bus.i_rs1;
  assign w_mag_b = w_sb ? -bus.i_rs2 : bus.i_rs2;

  assign w_div0 = w_is_div & (bus.i_rs2 == '0);
  assign w_ovf  = w_is_div & ~bus.i_funct3[0] & (bus.i_rs2 == '1)
                  & (bus.i_rs1 == {1'b1, {(XLEN-1){1'b0}}});

  always_comb begin
    if (w_div0) w_special = bus.i_funct3[1] ? bus.i_rs1 : '1;
    else        w_special = bus.i_funct3[1] ? '0 : bus.i_rs1;
  end

  // Multiply step: hi accumulates, lo holds the multiplier and collects product low bits.
  logic [XLEN:0]     w_acc;
  logic [XLEN-1:0]   w_mul_hi, w_mul_lo;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_mul_res;

  assign w_acc    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign w_mul_hi = w_acc[XLEN:1];
  assign w_mul_lo = {w_acc[0], lo_q[XLEN-1:1]};
  assign w_prod   = {w_mul_hi, w_mul_lo};
  assign w_prod_s = neg_q ? -w_prod : w_prod;
  assign w_mul_res = (f3_q[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];

  // Divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [XLEN:0]   w_shift, w_diff;
  logic [XLEN-1:0] w_div_hi, w_div_lo;
  logic [XLEN-1:0] w_quo, w_rem, w_div_res;

  assign w_shift   = {hi_q, lo_q[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, b_q};
  assign w_div_hi  = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_div_lo  = {lo_q[XLEN-2:0], ~w_diff[XLEN]};
  assign w_quo     = neg_q ? -w_div_lo : w_div_lo;
  assign w_rem     = sa_q ? -w_div_hi : w_div_hi;
  assign w_div_res = f3_q[1] ? w_rem : w_quo;

  assign w_last = (cnt_q == CW'(XLEN-1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          f3_d  = bus.i_funct3;
          hi_d  = '0;
          lo_d  = w_mag_a;
          b_d   = w_mag_b;
          neg_d = w_sa ^ w_sb;
          sa_d  = w_sa;
          cnt_d = '0;
          if (w_div0 | w_ovf) begin
            res_d   = w_special;
            state_d = S_DONE;
          end else begin
            state_d = w_is_div ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        hi_d  = w_mul_hi;
        lo_d  = w_mul_lo;
        cnt_d = cnt_q + 1'b1;
        if (w_last) begin
          res_d   = w_mul_res;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        hi_d  = w_div_hi;
        lo_d  = w_div_lo;
        cnt_d = cnt_q + 1'b1;
        if (w_last) begin
          res_d   = w_div_res;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A killed instruction never updates the visible result.
    if (bus.i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      res_q   <= res_d;
    end
  end

  assign bus.o_is_mdu     = w_is_mdu;
  assign bus.o_stall      = w_accept | (state_q == S_MUL) | (state_q == S_DIV);
  assign bus.o_mdu_valid  = (state_q == S_DONE) & ~bus.i_flush;
  assign bus.o_mdu_result = res_q;

endmodule
`default_nettype wire
